// File: rtl/seq_pkg.sv
// Shared definitions for the "1001" sequence path: serializer FSM encodings,
// detector state constants and a constant-evaluable clog2 helper.
package seq_pkg;

    // Serializer FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    // Overlapping "1001" Moore detector states, named by the matched suffix.
    typedef enum logic [2:0] {
        DET_S0    = 3'd0,
        DET_S1    = 3'd1,
        DET_S10   = 3'd2,
        DET_S100  = 3'd3,
        DET_S1001 = 3'd4
    } det_state_t;

    // Ceiling log2; used to size counters from parameters at elaboration.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the "1001" detector. Words are accepted over
// valid/ready and shifted out one bit per clock on o_x; a word accepted on the
// last-bit edge follows with no idle bubble, so patterns can span words.
// Optional macro SEQ_SER_PARITY_EN appends an even-parity bit to every frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame in flight; o_x = P_IDLE_BIT, ready for a word
// ST_SHIFT | bit cnt of the current frame is on o_x; ready on last bit
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int P_WIDTH     = 8,
    parameter bit P_MSB_FIRST = 1'b1,
    parameter bit P_IDLE_BIT  = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [P_WIDTH-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_x,
    output logic               o_x_valid,
    output logic               o_busy
);

`ifdef SEQ_SER_PARITY_EN
    localparam int FRAME_LEN = P_WIDTH + 1;
`else
    localparam int FRAME_LEN = P_WIDTH;
`endif
    localparam int               CNT_W    = clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    ser_state_t         state, state_nxt;
    logic [P_WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               x_nxt, x_valid_nxt, busy_nxt;
    logic               xfer;
    logic               first_bit;
    logic               next_bit;
    logic [P_WIDTH-1:0] shifted;
`ifdef SEQ_SER_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(P_WIDTH - 1);
    logic               par, par_nxt;
`endif

    // Ready while idle or while the final bit of the frame is on the wire.
    assign o_ready = i_reset && ((state == ST_IDLE) ||
                                 ((state == ST_SHIFT) && (cnt == LAST_CNT)));
    assign xfer    = i_valid && o_ready;

    // Shift direction and the bit that appears next are fixed by P_MSB_FIRST.
    assign first_bit = P_MSB_FIRST ? i_data[P_WIDTH-1] : i_data[0];
    assign next_bit  = P_MSB_FIRST ? shreg[P_WIDTH-2]  : shreg[1];
    assign shifted   = P_MSB_FIRST ? (shreg << 1)      : (shreg >> 1);

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        x_nxt       = o_x;
        x_valid_nxt = o_x_valid;
        busy_nxt    = o_busy;
`ifdef SEQ_SER_PARITY_EN
        par_nxt     = par;
`endif
        if (xfer) begin
            // Same action from idle and from the last bit: back-to-back reload.
            state_nxt   = ST_SHIFT;
            shreg_nxt   = i_data;
            cnt_nxt     = '0;
            x_nxt       = first_bit;
            x_valid_nxt = 1'b1;
            busy_nxt    = 1'b1;
`ifdef SEQ_SER_PARITY_EN
            par_nxt     = ^i_data;
`endif
        end else if (state == ST_IDLE || cnt == LAST_CNT) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
            x_nxt       = P_IDLE_BIT;
            x_valid_nxt = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            shreg_nxt = shifted;
            cnt_nxt   = cnt + CNT_W'(1);
            x_nxt     = next_bit;
`ifdef SEQ_SER_PARITY_EN
            // After the last data bit the stored parity goes out.
            if (cnt == LAST_DATA_CNT) begin
                x_nxt = par;
            end
`endif
        end
    end

    // State, datapath and output registers; reset abandons any frame at once.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            o_x       <= P_IDLE_BIT;
            o_x_valid <= 1'b0;
            o_busy    <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            o_x       <= x_nxt;
            o_x_valid <= x_valid_nxt;
            o_busy    <= busy_nxt;
`ifdef SEQ_SER_PARITY_EN
            par       <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: an MSB-first and an LSB-first
// instance, a vector table of single frames, plus back-to-back, held-word
// and mid-frame reset sequences. Adapts to SEQ_SER_PARITY_EN.
module tb_seq_bit_serializer;

`ifdef SEQ_SER_PARITY_EN
    localparam int FL       = 9;
    localparam int WIN_B2B  = 3;
    localparam int WIN_HOLD = 3;
`else
    localparam int FL       = 8;
    localparam int WIN_B2B  = 4;
    localparam int WIN_HOLD = 2;
`endif

    typedef struct {
        logic [7:0] data;
        bit         msb;
        logic [7:0] bits;   // transmission order, first bit in [7]
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d_m = '0, d_l = '0;
    logic       v_m = 1'b0, v_l = 1'b0;
    logic       r_m, x_m, xv_m, b_m;
    logic       r_l, x_l, xv_l, b_l;

    int checks = 0;
    int errors = 0;

    vec_t vecs[7];

    always #5 clk = ~clk;

    seq_bit_serializer #(.P_WIDTH(8), .P_MSB_FIRST(1'b1), .P_IDLE_BIT(1'b0)) dut_m (
        .i_clk(clk), .i_reset(rst_n), .i_data(d_m), .i_valid(v_m),
        .o_ready(r_m), .o_x(x_m), .o_x_valid(xv_m), .o_busy(b_m)
    );

    seq_bit_serializer #(.P_WIDTH(8), .P_MSB_FIRST(1'b0), .P_IDLE_BIT(1'b0)) dut_l (
        .i_clk(clk), .i_reset(rst_n), .i_data(d_l), .i_valid(v_l),
        .o_ready(r_l), .o_x(x_l), .o_x_valid(xv_l), .o_busy(b_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {o_x, o_x_valid, o_busy, o_ready}
    function automatic logic [3:0] outs(input bit msb);
        return msb ? {x_m, xv_m, b_m, r_m} : {x_l, xv_l, b_l, r_l};
    endfunction

    function automatic logic [FL-1:0] frame(input logic [7:0] b, input logic p);
        logic [8:0] t;
        t = {b, p};
        return t[8 -: FL];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic [FL-1:0] fr;
        v  = vecs[idx];
        fr = frame(v.bits, v.par);
        if (v.msb) begin d_m = v.data; v_m = 1'b1; end
        else       begin d_l = v.data; v_l = 1'b1; end
        step();
        v_m = 1'b0;
        v_l = 1'b0;
        for (int k = 0; k < FL; k++) begin
            check($sformatf("vec%0d bit%0d", idx, k), 32'(outs(v.msb)),
                  32'({fr[FL-1-k], 1'b1, 1'b1, (k == FL-1)}));
            step();
        end
        check($sformatf("vec%0d idle", idx), 32'(outs(v.msb)), 32'(4'b0001));
    endtask

    // Two frames on the MSB-first instance; the second word is presented
    // (valid raised) at sample point raise_k of the first frame.
    task automatic two_frames(input string name, input logic [7:0] w0, input logic [7:0] w1,
                              input logic [2*FL-1:0] stream, input int raise_k,
                              input int exp_windows);
        logic [2*FL-1:0] cap;
        int win;
        cap = '0;
        d_m = w0;
        v_m = 1'b1;
        step();
        d_m = w1;
        v_m = (raise_k == 0);
        for (int k = 0; k < 2*FL; k++) begin
            if (k == raise_k) v_m = 1'b1;
            if (k == FL)      v_m = 1'b0;
            cap[2*FL-1-k] = x_m;
            check($sformatf("%s bit%0d", name, k), 32'(outs(1'b1)),
                  32'({stream[2*FL-1-k], 1'b1, 1'b1, (k == FL-1) || (k == 2*FL-1)}));
            step();
        end
        check($sformatf("%s idle", name), 32'(outs(1'b1)), 32'(4'b0001));
        win = 0;
        for (int i = 0; i <= 2*FL-4; i++) begin
            if (cap[2*FL-1-i -: 4] == 4'b1001) win++;
        end
        check($sformatf("%s 1001 count", name), 32'(win), 32'(exp_windows));
    endtask

    initial begin
        vecs[0] = '{data: 8'h93, msb: 1'b1, bits: 8'b1001_0011, par: 1'b0};
        vecs[1] = '{data: 8'h93, msb: 1'b0, bits: 8'b1100_1001, par: 1'b0};
        vecs[2] = '{data: 8'hA5, msb: 1'b1, bits: 8'b1010_0101, par: 1'b0};
        vecs[3] = '{data: 8'h01, msb: 1'b0, bits: 8'b1000_0000, par: 1'b1};
        vecs[4] = '{data: 8'h80, msb: 1'b1, bits: 8'b1000_0000, par: 1'b1};
        vecs[5] = '{data: 8'h92, msb: 1'b1, bits: 8'b1001_0010, par: 1'b1};
        vecs[6] = '{data: 8'h6E, msb: 1'b0, bits: 8'b0111_0110, par: 1'b1};

        // Reset values, including o_ready forced low.
        #3;
        check("reset msb", 32'(outs(1'b1)), 32'(4'b0000));
        check("reset lsb", 32'(outs(1'b0)), 32'(4'b0000));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post-reset msb", 32'(outs(1'b1)), 32'(4'b0001));
        check("post-reset lsb", 32'(outs(1'b0)), 32'(4'b0001));

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        // 8'h93 then 8'h27 with valid held: contiguous stream, cross-word 1001.
        two_frames("b2b", 8'h93, 8'h27, {frame(8'h93, 1'b0), frame(8'h27, 1'b0)}, 0, WIN_B2B);

        // 8'h55 offered at cycle 3 of an 8'h93 frame waits for the last bit.
        two_frames("hold", 8'h93, 8'h55, {frame(8'h93, 1'b0), frame(8'h55, 1'b0)}, 2, WIN_HOLD);

        // Reset asserted during bit 5 of 8'hF0.
        d_m = 8'hF0;
        v_m = 1'b1;
        step();
        v_m = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst F0 bit%0d", k), 32'(outs(1'b1)), 32'(4'b1110));
            step();
        end
        check("rst F0 bit4", 32'(outs(1'b1)), 32'(4'b0110));
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset", 32'(outs(1'b1)), 32'(4'b0000));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset release", 32'(outs(1'b1)), 32'(4'b0001));
        step();
        check("reset idle", 32'(outs(1'b1)), 32'(4'b0001));
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the overlapping "1001" Moore sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on o_x, which drives the detector's i_x.
- Supports back-to-back words with no idle bubble, so the detector sees a continuous bit stream across word boundaries.
- Overlapping patterns that span two words are therefore detectable.

Parameters:
- P_WIDTH, 8, data word width in bits; legal range 2..32.
- P_MSB_FIRST, 1, 1 = transmit bit P_WIDTH-1 first; 0 = transmit bit 0 first.
- P_IDLE_BIT, 0, value driven on o_x whenever o_x_valid is low.

Ports:
- i_clk  input  1  single system clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_data  input  P_WIDTH  parallel word to serialize.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  block will accept i_data on this edge.
- o_x  output  1  serial bit; connects to the detector's i_x.
- o_x_valid  output  1  o_x carries a data (or parity) bit.
- o_busy  output  1  a frame is being shifted out.

Behaviour:
- Clock and reset: one clock (i_clk). Reset is asynchronous and active-low on i_reset.
- Reset values:
  - state = ST_IDLE, shift register = 0, bit counter = 0.
  - o_x = P_IDLE_BIT, o_x_valid = 0, o_busy = 0.
  - o_ready is forced 0 while i_reset is low.
- States: ST_IDLE and ST_SHIFT, 1-bit encoding.
- Handshake: a transfer occurs on a rising edge where i_valid && o_ready. i_data is ignored otherwise. i_valid may be held across cycles.
- o_ready is combinational: high when i_reset is high and either
  - state == ST_IDLE, or
  - state == ST_SHIFT and the bit counter == FRAME_LEN-1 (last bit on output).
- FRAME_LEN = P_WIDTH, or P_WIDTH+1 with the parity feature.
- ST_IDLE:
  - On transfer: load the shift register, counter = 0, go to ST_SHIFT.
  - The first bit appears on o_x with o_x_valid = 1 in the cycle after the accepting edge (latency 1).
  - Without a transfer: o_x = P_IDLE_BIT, o_x_valid = 0.
- ST_SHIFT:
  - Each edge advances one bit (left shift if MSB-first, right shift otherwise) and increments the counter.
  - o_x, o_x_valid and o_busy are registered outputs.
- Last bit (counter == FRAME_LEN-1):
  - Transfer on that edge: reload, counter = 0, stay in ST_SHIFT. No gap; o_x_valid stays 1.
  - No transfer: go to ST_IDLE. o_x_valid drops and o_x returns to P_IDLE_BIT the next cycle.
- Counter width is clog2(FRAME_LEN+1). The counter never exceeds FRAME_LEN-1; no wrap beyond a frame.
- Reset mid-frame: the frame is abandoned immediately (asynchronously) and all outputs take their reset values. No partial resume after reset release.
- i_valid while busy and not on the last bit: no transfer, and the word is held by the source.

Optional Feature:
- Macro: SEQ_SER_PARITY_EN.
- Defined: an even-parity bit (XOR of the P_WIDTH data bits) is appended as the final bit of every frame, with o_x_valid = 1. FRAME_LEN = P_WIDTH+1 and o_ready rises on the parity-bit cycle.
- Undefined: no parity logic, FRAME_LEN = P_WIDTH.

Decomposition:
- Shared package/include seq_pkg: ST_IDLE/ST_SHIFT encodings and the clog2 helper function. The detector's state constants move into seq_pkg as well.
- No sub-module; a single flat module (FSM, shift register, counter) is sufficient.

Test Plan:
- Reset, then i_valid=1 with i_data=8'h93, P_MSB_FIRST=1 -> o_x = 1,0,0,1,0,0,1,1 on cycles 1..8 with o_x_valid=1. Detector o_seq_detected is high the cycle after bit 4 and the cycle after bit 7.
- Back-to-back 8'h93 then 8'h27 (i_valid held) -> o_ready=1 on cycle 8 only. 16 contiguous valid bits, o_x_valid never drops. Cross-word "1001" (bits 7..10 = 1,1,0,0 → none; bits 8..11 = 1,0,0,1 → detect) is reported.
- P_MSB_FIRST=0, i_data=8'h93 -> o_x = 1,1,0,0,1,0,0,1. After the frame, o_x = P_IDLE_BIT and o_x_valid=0.
- i_valid asserted with 8'h55 at cycle 3 of an 8'h93 frame -> no transfer until the last-bit cycle. 8'h55 bits follow 8'h93 immediately.
- Assert i_reset=0 during bit 5 of 8'hF0 -> o_x_valid=0, o_busy=0, o_ready=0 asynchronously. After release, o_ready=1 and the next word starts cleanly from bit 0.
- SEQ_SER_PARITY_EN, i_data=8'h93 (four ones) -> 9 bits, 9th bit = 0. With i_data=8'h92 -> 9th bit = 1. o_ready is high on the 9th-bit cycle.
